// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states,
// opcode classes and the datapath select codes.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CLS_R, CLS_I, CLS_CNTZ, CLS_LUI, CLS_AUIPC,
    CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_JALR
  } op_class_t;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
  localparam logic [1:0] ALU_CNTZ   = 2'b11;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_TARGET = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;

  localparam logic [1:0] SRC_A_RS1  = 2'd0;
  localparam logic [1:0] SRC_A_PC   = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;
  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

endpackage

// File: rtl/opcode_classify.sv
// Combinational opcode-to-class decoder; flags opcodes the core cannot execute.
module opcode_classify
  import ctrl_pkg::*;
#(
  parameter logic [6:0] CNTZ_OPCODE = 7'b1111111,
  parameter bit         ENABLE_JUMP = 1'b1
) (
  input  logic [6:0] opcode,
  output op_class_t  op_class,
  output logic       illegal
);

  // The custom opcode is tested first so it overrides a standard encoding it may alias.
  always_comb begin
    op_class = CLS_R;
    illegal  = 1'b0;
    if (opcode == CNTZ_OPCODE) begin
      op_class = CLS_CNTZ;
    end else begin
      case (opcode)
        OP_R:      op_class = CLS_R;
        OP_I:      op_class = CLS_I;
        OP_LOAD:   op_class = CLS_LOAD;
        OP_STORE:  op_class = CLS_STORE;
        OP_BRANCH: op_class = CLS_BRANCH;
        OP_JAL:    begin op_class = CLS_JAL;   illegal = !ENABLE_JUMP; end
        OP_JALR:   begin op_class = CLS_JALR;  illegal = !ENABLE_JUMP; end
        OP_LUI:    begin op_class = CLS_LUI;   illegal = !ENABLE_JUMP; end
        OP_AUIPC:  begin op_class = CLS_AUIPC; illegal = !ENABLE_JUMP; end
        default:   illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RISC-V control FSM: FETCH/DECODE/EXEC/MEM/WB with a sticky
// illegal-opcode trap and a variable-latency memory handshake.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter logic [6:0] CNTZ_OPCODE = 7'b1111111,
  parameter bit         ENABLE_JUMP = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       branch_cond,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       illegal,
  output logic [2:0] state
);

  state_t    cur_state;
  op_class_t cls;
  op_class_t dec_class;
  logic      dec_illegal;

  opcode_classify #(
    .CNTZ_OPCODE(CNTZ_OPCODE),
    .ENABLE_JUMP(ENABLE_JUMP)
  ) u_classify (
    .opcode  (opcode),
    .op_class(dec_class),
    .illegal (dec_illegal)
  );

  // The class is latched in DECODE so the IR may change freely afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= ST_FETCH;
      cls       <= CLS_R;
    end else begin
      case (cur_state)
        ST_FETCH: if (mem_ready) cur_state <= ST_DECODE;
        ST_DECODE: begin
          cls       <= dec_class;
          cur_state <= dec_illegal ? ST_TRAP : ST_EXEC;
        end
        ST_EXEC: begin
          case (cls)
            CLS_LOAD, CLS_STORE: cur_state <= ST_MEM;
            CLS_BRANCH:          cur_state <= ST_FETCH;
            default:             cur_state <= ST_WB;
          endcase
        end
        ST_MEM: if (mem_ready) cur_state <= (cls == CLS_LOAD) ? ST_WB : ST_FETCH;
        ST_WB:   cur_state <= ST_FETCH;
        ST_TRAP: cur_state <= ST_TRAP;
        default: cur_state <= ST_FETCH;
      endcase
    end
  end

  // Reset forces every output low, even before the state register has settled.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_PLUS4;
    alu_src_a = SRC_A_RS1;
    alu_src_b = SRC_B_RS2;
    alu_op    = ALU_ADD;
    reg_write = 1'b0;
    wb_sel    = WB_ALU;
    illegal   = 1'b0;
    state     = 3'd0;
    if (!rst) begin
      state = cur_state;
      case (cur_state)
        ST_FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        ST_EXEC: begin
          case (cls)
            CLS_R:     alu_op = ALU_FUNCT;
            CLS_I:     begin alu_src_b = SRC_B_IMM; alu_op = ALU_FUNCT; end
            CLS_CNTZ:  alu_op = ALU_CNTZ;
            CLS_LUI:   begin alu_src_a = SRC_A_ZERO; alu_src_b = SRC_B_IMM; end
            CLS_AUIPC: begin alu_src_a = SRC_A_PC;   alu_src_b = SRC_B_IMM; end
            CLS_LOAD, CLS_STORE: alu_src_b = SRC_B_IMM;
            CLS_BRANCH: begin
              alu_op   = ALU_BRANCH;
              pc_write = branch_cond;
              pc_src   = PC_TARGET;
            end
            CLS_JAL:   begin pc_write = 1'b1; pc_src = PC_TARGET; end
            CLS_JALR: begin
              alu_src_b = SRC_B_IMM;
              pc_write  = 1'b1;
              pc_src    = PC_JALR;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          mem_req = 1'b1;
          mem_we  = (cls == CLS_STORE);
        end
        ST_WB: begin
          reg_write = 1'b1;
          case (cls)
            CLS_LOAD:          wb_sel = WB_MEM;
            CLS_JAL, CLS_JALR: wb_sel = WB_PC4;
            default:           wb_sel = WB_ALU;
          endcase
        end
        ST_TRAP: illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Parametrised multi-cycle successor to the single-cycle main control decoder. Sequences each RISC-V instruction through FETCH/DECODE/EXEC/MEM/WB states, drives datapath enables, and handshakes with a variable-latency unified memory. Adds JAL/JALR/LUI/AUIPC decoding, a configurable custom count-zero opcode, and an illegal-opcode trap. Sits between the instruction register and the shared datapath (PC, register file, ALU, memory port).

## Interface
- CNTZ_OPCODE, 7'b1111111, opcode of the custom count-zero instruction (ALU op class 2'b11)
- ENABLE_JUMP, 1, when 0, JAL/JALR/LUI/AUIPC decode as illegal
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high (already decided)
- opcode  in  7  instruction[6:0] from the instruction register, stable from DECODE onward
- mem_ready  in  1  memory completes the pending request this cycle
- branch_cond  in  1  comparator result for the current branch, valid in EXEC
- mem_req  out  1  memory request; held until mem_ready
- mem_we  out  1  write qualifier for mem_req
- ir_write  out  1  load instruction register
- pc_write  out  1  load PC
- pc_src  out  2  0 = PC+4, 1 = branch/JAL target, 2 = JALR target (ALU result)
- alu_src_a  out  2  0 = rs1, 1 = PC, 2 = zero
- alu_src_b  out  2  0 = rs2, 1 = immediate
- alu_op  out  2  00 add, 01 branch compare, 10 funct-decoded, 11 count-zero
- reg_write  out  1  register-file write enable
- wb_sel  out  2  0 = ALU, 1 = memory data, 2 = PC+4
- illegal  out  1  sticky trap flag
- state  out  3  current state encoding, for debug

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH: mem_req=1, mem_we=0. On mem_ready, assert ir_write=1, pc_write=1, and pc_src=0 in that cycle, then go to DECODE. Otherwise stay.
- DECODE: one cycle. An unrecognised opcode (or a jump-class opcode with ENABLE_JUMP=0) goes to TRAP. Everything else goes to EXEC.
- EXEC by class:
  - R (0110011): alu_src b=0, alu_op=10.
  - I (0010011): alu_src b=1, alu_op=10.
  - CNTZ: alu_op=11.
  - LUI: a=2, b=1.
  - AUIPC: a=1, b=1.
  - Each of the above then goes to WB.
  - Load/store: a=0, b=1, alu_op=00, then go to MEM.
  - Branch (1100011): alu_op=01, pc_write=branch_cond, pc_src=1, then go to FETCH.
  - JAL: pc_write=1, pc_src=1, then go to WB.
  - JALR: a=0, b=1, pc_write=1, pc_src=2, then go to WB.
- MEM: mem_req=1, mem_we=1 for store. Hold until mem_ready. On mem_ready, a load goes to WB and a store goes to FETCH.
- WB: reg_write=1 for exactly one cycle. wb_sel is 1 for load, 2 for JAL/JALR, 0 otherwise. Then go to FETCH.
- TRAP: illegal=1. All enables are 0. Only rst exits TRAP.
- Outputs not listed for a state are 0.

## Timing
- Reset: while rst=1, every output is 0 (including mem_req). On the first edge with rst=0, state is FETCH. Asserting rst mid-instruction, including mid-MEM, abandons the instruction on the next edge with no reg_write or pc_write.
- Cycle counts with zero-wait memory:
  - R/I/CNTZ/LUI/AUIPC/JAL/JALR: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - Each memory wait cycle adds 1.
- mem_req, mem_we, and the address-selecting outputs stay stable from assertion until the mem_ready cycle inclusive.
- mem_ready outside FETCH/MEM is ignored.
- pc_write and ir_write are combinational on mem_ready and branch_cond. All other outputs are pure functions of state and the latched opcode class.
- Opcode class is captured in DECODE, so later changes to opcode are ignored until the next DECODE.

## Structure
- Package ctrl_pkg holds:
  - opcode constants (R, I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC);
  - state enum;
  - alu_op, pc_src, alu_src, and wb_sel encodings;
  - an opcode-class enum.
- Sub-module opcode_classify: combinational opcode to class/illegal decoder, parameterised by CNTZ_OPCODE and ENABLE_JUMP. The FSM and output decode live in multicycle_control.

## Test plan
- Reset held 3 cycles, then released with mem_ready=1 and opcode=0110011 -> all outputs 0 during reset, then FETCH, DECODE, EXEC, WB with reg_write=1 and wb_sel=0 in cycle 4, then FETCH again.
- Load (0000011) with mem_ready low for 2 cycles in MEM -> mem_req=1 and mem_we=0 steady for 3 MEM cycles, then WB with wb_sel=1; 7 cycles total.
- Branch with branch_cond=1, then a second branch with branch_cond=0 -> pc_write=1 and pc_src=1 in EXEC only for the first; both take 3 cycles; no reg_write.
- JALR with ENABLE_JUMP=1 -> EXEC has pc_write=1 and pc_src=2; WB has wb_sel=2. Same opcode with ENABLE_JUMP=0 -> TRAP with illegal=1, held for 10 cycles until rst.
- Opcode 1111111 (default CNTZ_OPCODE) -> alu_op=11 in EXEC and reg_write in WB. Opcode 0000000 -> TRAP.
- Store with rst asserted during the second MEM wait cycle -> next cycle all outputs 0; after release, restart in FETCH.
